// File: rtl/gals_burst_producer.sv
// Producer-domain burst generator feeding the dual-clock buffer write port.
// Emits incrementing or Galois-LFSR words, throttled by a synchronised full flag.
module gals_burst_producer #(
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned LEN_WIDTH   = 8,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned GAP_CYCLES  = 1
) (
  input  logic                  clock_1,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  mode,
  input  logic [DATA_WIDTH-1:0] seed,
  input  logic [LEN_WIDTH-1:0]  burst_len,
  input  logic                  buffer_full,
  output logic [DATA_WIDTH-1:0] data_1,
  output logic                  data_1_en,
  output logic                  busy,
  output logic                  done,
  output logic [LEN_WIDTH-1:0]  sent_count,
  output logic [DATA_WIDTH-1:0] checksum
);

  localparam int unsigned GapW = (GAP_CYCLES < 2) ? 1 : $clog2(GAP_CYCLES + 1);
  localparam logic [DATA_WIDTH-1:0] LfsrMask = DATA_WIDTH'(16'hB400);

  typedef enum logic [2:0] {StIdle, StSend, StGap, StStall, StDone} state_e;

  state_e                 state_q;
  logic [SYNC_STAGES-1:0] sync_q;
  logic [DATA_WIDTH-1:0]  cur_q;
  logic [LEN_WIDTH-1:0]   len_q;
  logic                   mode_q;
  logic [GapW-1:0]        gap_q;

  logic                  in_idle, stall, issue, issue_mode;
  logic [DATA_WIDTH-1:0] start_word, issue_word, issue_sum;
  logic [LEN_WIDTH-1:0]  issue_len, issue_count;

  function automatic logic [DATA_WIDTH-1:0] next_word(input logic                  m,
                                                      input logic [DATA_WIDTH-1:0] w);
    if (m) return (w >> 1) ^ (w[0] ? LfsrMask : {DATA_WIDTH{1'b0}});
    return w + DATA_WIDTH'(1);
  endfunction

  // Issue operands come straight from the inputs on the start edge, else from latched state.
  always_comb begin
    in_idle     = (state_q == StIdle);
    stall       = buffer_full | sync_q[SYNC_STAGES-1];
    start_word  = (mode && seed == '0) ? DATA_WIDTH'(1) : seed;
    issue_word  = in_idle ? start_word : cur_q;
    issue_mode  = in_idle ? mode : mode_q;
    issue_len   = in_idle ? burst_len : len_q;
    issue_count = (in_idle ? {LEN_WIDTH{1'b0}} : sent_count) + LEN_WIDTH'(1);
    issue_sum   = (in_idle ? {DATA_WIDTH{1'b0}} : checksum) + issue_word;
    issue       = !stall && ((in_idle && start && burst_len != '0) ||
                             state_q == StSend || state_q == StStall);
  end

  always_ff @(posedge clock_1) begin
    if (!reset) begin
      state_q    <= StIdle;
      sync_q     <= '0;
      cur_q      <= '0;
      len_q      <= '0;
      mode_q     <= 1'b0;
      gap_q      <= '0;
      data_1     <= '0;
      data_1_en  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      sent_count <= '0;
      checksum   <= '0;
    end else begin
      sync_q    <= {sync_q[SYNC_STAGES-2:0], buffer_full};
      data_1_en <= 1'b0;
      done      <= 1'b0;
      if (issue) begin
        data_1     <= issue_word;
        data_1_en  <= 1'b1;
        sent_count <= issue_count;
        checksum   <= issue_sum;
        cur_q      <= next_word(issue_mode, issue_word);
        mode_q     <= issue_mode;
        len_q      <= issue_len;
        if (issue_count == issue_len) begin
          state_q <= StDone;
          done    <= 1'b1;
          busy    <= 1'b0;
        end else begin
          state_q <= StGap;
          gap_q   <= GapW'(GAP_CYCLES);
          busy    <= 1'b1;
        end
      end else begin
        unique case (state_q)
          StIdle: begin
            if (start) begin
              mode_q     <= mode;
              len_q      <= burst_len;
              sent_count <= '0;
              checksum   <= '0;
              if (burst_len == '0) begin
                state_q <= StDone;
                done    <= 1'b1;
                busy    <= 1'b0;
              end else begin
                // Stalled on the start edge: hold the first word until the flag clears.
                busy    <= 1'b1;
                cur_q   <= start_word;
                state_q <= StStall;
              end
            end
          end
          StSend, StStall: state_q <= StStall;
          StGap: begin
            gap_q <= gap_q - GapW'(1);
            if (gap_q <= GapW'(1)) state_q <= StSend;
          end
          StDone:  state_q <= StIdle;
          default: state_q <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_gals_burst_producer.sv
// Directed plus randomized bench for gals_burst_producer against a word-list reference model.
module tb_gals_burst_producer;
  localparam int DW   = 16;
  localparam int LW   = 8;
  localparam int SYNC = 2;
  localparam int GAP  = 1;

  logic          clock_1 = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic          mode = 1'b0;
  logic [DW-1:0] seed = '0;
  logic [LW-1:0] burst_len = '0;
  logic          buffer_full = 1'b0;
  logic [DW-1:0] data_1;
  logic          data_1_en;
  logic          busy;
  logic          done;
  logic [LW-1:0] sent_count;
  logic [DW-1:0] checksum;

  int total = 0;
  int bad = 0;

  always #5 clock_1 = ~clock_1;

  gals_burst_producer #(
    .DATA_WIDTH (DW),
    .LEN_WIDTH  (LW),
    .SYNC_STAGES(SYNC),
    .GAP_CYCLES (GAP)
  ) dut (
    .clock_1    (clock_1),
    .reset      (reset),
    .start      (start),
    .mode       (mode),
    .seed       (seed),
    .burst_len  (burst_len),
    .buffer_full(buffer_full),
    .data_1     (data_1),
    .data_1_en  (data_1_en),
    .busy       (busy),
    .done       (done),
    .sent_count (sent_count),
    .checksum   (checksum)
  );

  logic [DW-1:0] exp_q[$];
  int            cyc = 0;
  int            got = 0;
  int            last_strobe = -100;
  bit            prev_en = 1'b0;
  bit            check_spacing = 1'b0;
  logic [SYNC:0] hist = '0;  // buffer_full as sampled at the most recent edges

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp_v);
    end
  endtask

  // Expected word stream and checksum straight from the word-generation rules.
  task automatic build_model(input bit m, input logic [DW-1:0] s, input int len,
                             output logic [DW-1:0] sum);
    logic [DW-1:0] w;
    exp_q.delete();
    sum = '0;
    w = (m && s == 0) ? 16'h0001 : s;
    for (int i = 0; i < len; i++) begin
      exp_q.push_back(w);
      sum = sum + w;
      if (m) w = (w >> 1) ^ (w[0] ? 16'hB400 : 16'h0000);
      else   w = w + 16'd1;
    end
  endtask

  task automatic tick();
    @(posedge clock_1);
    hist = {hist[SYNC-1:0], buffer_full};
    cyc++;
    #1;
    if (data_1_en === 1'b1) begin
      // Full seen now, or SYNC_STAGES edges ago, forbids an issue on this edge.
      chk("issue_while_stalled", 32'(hist[0] | hist[SYNC]), 32'd0);
      chk("back_to_back", 32'(prev_en), 32'd0);
      if (check_spacing && got > 0) chk("strobe_spacing", cyc - last_strobe, GAP + 1);
      chk("strobe_allowed", 32'(data_1_en), 32'(exp_q.size() != 0));
      if (exp_q.size() != 0) chk("word", data_1, exp_q.pop_front());
      got++;
      last_strobe = cyc;
    end
    prev_en = (data_1_en === 1'b1);
  endtask

  // plan: 0 free-running, 1 long full pulse after 2nd capture, 2 random full, 3 mid-burst start
  task automatic run_burst(input bit m, input logic [DW-1:0] s, input int len, input int plan);
    logic [DW-1:0] sum;
    int n = 0;
    bit saw = 1'b0;
    int rise = -1;
    int drop = -1;
    bit chk3 = 1'b0;
    bit poked = 1'b0;
    build_model(m, s, len, sum);
    got = 0;
    check_spacing = (plan == 0);
    mode = m;
    seed = s;
    burst_len = LW'(len);
    start = 1'b1;
    tick();
    start = 1'b0;
    while (!saw && n < 1000) begin
      if (done === 1'b1) saw = 1'b1;
      else begin
        if (len != 0) chk("busy_during_burst", 32'(busy), 32'd1);
        if (plan == 1) begin
          if (got == 2 && rise < 0) begin
            rise = cyc + 1;
            drop = cyc + 11;
          end
          if (got == 3 && !chk3) begin
            chk3 = 1'b1;
            chk("stall_release_edge", last_strobe, drop + 1 + SYNC);
          end
          buffer_full = (rise >= 0 && cyc >= rise && cyc < drop);
        end else if (plan == 2) begin
          buffer_full = ($urandom_range(0, 3) == 0);
        end else if (plan == 3) begin
          start = (got == 2 && !poked);
          if (start) begin
            poked = 1'b1;
            seed = ~s;
            burst_len = 8'd2;
            mode = ~m;
          end
        end
        tick();
        n++;
      end
    end
    buffer_full = 1'b0;
    start = 1'b0;
    chk("done_seen", 32'(saw), 32'd1);
    if (len == 0) chk("done_latency", n, 0);
    chk("words_left", exp_q.size(), 0);
    chk("sent_count", sent_count, len);
    chk("checksum", checksum, sum);
    chk("busy_at_done", 32'(busy), 32'd0);
    tick();
    chk("done_one_cycle", 32'(done), 32'd0);
    chk("sent_count_hold", sent_count, len);
    chk("checksum_hold", checksum, sum);
  endtask

  initial begin
    logic [DW-1:0] rsum;
    reset = 1'b0;
    repeat (3) tick();
    chk("rst_data", data_1, 0);
    chk("rst_en", 32'(data_1_en), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_count", sent_count, 0);
    chk("rst_checksum", checksum, 0);
    reset = 1'b1;
    tick();

    run_burst(1'b0, 16'h00FF, 4, 0);
    chk("inc_checksum_const", checksum, 16'h0402);
    run_burst(1'b1, 16'h0000, 3, 0);
    chk("lfsr_checksum_const", checksum, 16'h0E01);
    run_burst(1'b0, 16'hFFFE, 3, 0);
    chk("wrap_checksum_const", checksum, 16'hFFFD);
    run_burst(1'b0, 16'h1234, 5, 1);
    run_burst(1'b0, 16'h5555, 0, 0);
    run_burst(1'b1, 16'hACE1, 6, 3);

    // Reset in the middle of a burst, then a fresh burst.
    build_model(1'b0, 16'h4000, 8, rsum);
    got = 0;
    mode = 1'b0;
    seed = 16'h4000;
    burst_len = 8'd8;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 50 && got < 2; i++) tick();
    chk("pre_reset_progress", got, 2);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    exp_q.delete();
    chk("mid_rst_data", data_1, 0);
    chk("mid_rst_en", 32'(data_1_en), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_done", 32'(done), 0);
    chk("mid_rst_count", sent_count, 0);
    chk("mid_rst_checksum", checksum, 0);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("no_done_after_reset", 32'(done), 0);
    end
    run_burst(1'b0, 16'h4000, 3, 0);

    for (int i = 0; i < 20; i++) begin
      run_burst(1'($urandom_range(0, 1)), 16'($urandom), int'($urandom_range(0, 12)), 2);
      repeat ($urandom_range(0, 3)) tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
